secded_counter: RTL and testbench

Parametrised up/down counter whose state register is protected by a Hamming code, with optional SECDED double-error detection. Every cycle the stored codeword is decoded. Single-bit upsets are corrected on the output and scrubbed back into storage, and uncorrectable errors freeze the count and raise a sticky flag. It replaces the fixed 16-bit Hamming counter in the fault-injection test top and is the counter primitive for radiation-hardened control paths.

---
 rtl/secded_counter_pkg.sv | 60 ++++++
 rtl/hamming_secded_codec.sv | 47 ++++
 rtl/secded_counter.sv | 105 ++++++++++
 tb/tb_secded_counter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_counter_pkg.sv
// Shared definitions for the Hamming/SECDED protected counter: code sizing, codeword position map, encoder.
// SECDED_COUNTER_DED_EN adds the overall parity bit (double-error detection); undefined builds pure SEC.
package secded_counter_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int MAX_HP    = 7;            // 2^7 >= 64 + 7 + 1
  localparam int MAX_P     = MAX_HP + 1;

`ifdef SECDED_COUNTER_DED_EN
  localparam bit DED_EN = 1'b1;
`else
  localparam bit DED_EN = 1'b0;
`endif

  function automatic int parity_bits(input int width, input bit ded);
    int p;
    p = 1;
    for (int i = 0; i < MAX_HP; i++) begin
      if ((1 << p) < width + p + 1) p++;
    end
    return ded ? p + 1 : p;
  endfunction

  // Codeword position (1-based) of data bit idx: the idx-th non-power-of-two position.
  function automatic int data_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p <= MAX_WIDTH + MAX_HP; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx && pos == 0) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // data must be zero above width; bit hp carries overall parity when ded is set.
  function automatic logic [MAX_P-1:0] hamming_encode(input logic [MAX_WIDTH-1:0] data,
                                                      input int width, input int hp,
                                                      input bit ded);
    logic [MAX_P-1:0] par;
    logic             ov;
    par = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        for (int j = 0; j < MAX_HP; j++) begin
          if (j < hp && ((data_pos(i) >> j) & 1) == 1) par[j] = par[j] ^ data[i];
        end
      end
    end
    ov = (^data) ^ (^par);
    for (int j = 0; j < MAX_P; j++) begin
      if (ded && j == hp) par[j] = ov;
    end
    return par;
  endfunction

endpackage

// File: rtl/hamming_secded_codec.sv
// Combinational Hamming decoder: syndrome, single-bit correction, uncorrectable detection.
// With DED the top parity bit is overall parity over the whole codeword.
module hamming_secded_codec
  import secded_counter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter bit DED   = 1'b0,
  parameter int P     = parity_bits(WIDTH, DED)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [P-1:0]     parity_i,
  output logic [WIDTH-1:0] data_o,
  output logic             single_o,
  output logic             double_o
);

  localparam int HP = DED ? P - 1 : P;
  localparam int N  = WIDTH + HP;

  logic [MAX_P-1:0] calc;
  logic [HP-1:0]    syn;
  logic             ov_bad;
  logic             syn_in_range;
  logic             unused_calc;

  assign unused_calc = ^calc;

  always_comb begin
    calc         = hamming_encode(MAX_WIDTH'(data_i), WIDTH, HP, 1'b0);
    syn          = calc[HP-1:0] ^ parity_i[HP-1:0];
    ov_bad       = (^data_i) ^ (^parity_i);
    syn_in_range = (int'(syn) <= N);
    if (DED) begin
      // Zero syndrome with bad overall parity means the overall bit itself flipped.
      single_o = ov_bad && syn_in_range;
      double_o = (!ov_bad && syn != '0) || (ov_bad && !syn_in_range);
    end else begin
      single_o = (syn != '0) && syn_in_range;
      double_o = !syn_in_range;
    end
    data_o = data_i;
    for (int i = 0; i < WIDTH; i++) begin
      if (single_o && int'(syn) == data_pos(i)) data_o[i] = ~data_i[i];
    end
  end

endmodule

// File: rtl/secded_counter.sv
// Up/down counter with Hamming-protected state; corrects and scrubs single upsets every cycle.
// Build with SECDED_COUNTER_DED_EN for double-error detection (overall parity bit).
module secded_counter
  import secded_counter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter,
  output logic             wrap,
  output logic             err_corrected,
  output logic             err_uncorrectable,
  output logic [CNT_W-1:0] corr_count
);

  localparam int P  = parity_bits(WIDTH, DED_EN);
  localparam int HP = parity_bits(WIDTH, 1'b0);

  logic [WIDTH-1:0] count_reg_q, count_reg_d;
  logic [P-1:0]     parity_stored_q, parity_stored_d;
  logic             wrap_q, wrap_d;
  logic             err_corr_q, err_corr_d;
  logic             err_unc_q, err_unc_d;
  logic [CNT_W-1:0] corr_count_q, corr_count_d;

  logic [WIDTH-1:0] corrected;
  logic [WIDTH-1:0] next_val;
  logic             single_err;
  logic             double_err;
  logic [MAX_P-1:0] enc_full;
  logic             unused_enc;

  hamming_secded_codec #(
    .WIDTH (WIDTH),
    .DED   (DED_EN),
    .P     (P)
  ) u_codec (
    .data_i   (count_reg_q),
    .parity_i (parity_stored_q),
    .data_o   (corrected),
    .single_o (single_err),
    .double_o (double_err)
  );

  assign enc_full   = hamming_encode(MAX_WIDTH'(next_val), WIDTH, HP, DED_EN);
  assign unused_enc = ^enc_full;

  always_comb begin
    next_val     = corrected;
    wrap_d       = 1'b0;
    err_corr_d   = 1'b0;
    err_unc_d    = err_unc_q;
    corr_count_d = corr_count_q;
    if (load) begin
      next_val  = load_value;
      err_unc_d = 1'b0;
    end else begin
      err_corr_d = single_err;
      if (single_err && corr_count_q != '1) corr_count_d = corr_count_q + CNT_W'(1);
      err_unc_d = err_unc_q | double_err;
      if (!(double_err || err_unc_q) && enable) begin
        next_val = up_down ? corrected + WIDTH'(1) : corrected - WIDTH'(1);
        wrap_d   = up_down ? (&corrected) : (corrected == '0);
      end
    end
    count_reg_d     = next_val;
    parity_stored_d = enc_full[P-1:0];
    // Uncorrectable storage is frozen untouched so the fault stays observable until load/reset.
    if (!load && (double_err || err_unc_q)) begin
      count_reg_d     = count_reg_q;
      parity_stored_d = parity_stored_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg_q     <= '0;
      parity_stored_q <= '0;  // valid encoding of zero
      wrap_q          <= 1'b0;
      err_corr_q      <= 1'b0;
      err_unc_q       <= 1'b0;
      corr_count_q    <= '0;
    end else begin
      count_reg_q     <= count_reg_d;
      parity_stored_q <= parity_stored_d;
      wrap_q          <= wrap_d;
      err_corr_q      <= err_corr_d;
      err_unc_q       <= err_unc_d;
      corr_count_q    <= corr_count_d;
    end
  end

  assign counter           = corrected;
  assign wrap              = wrap_q;
  assign err_corrected     = err_corr_q;
  assign err_uncorrectable = err_unc_q;
  assign corr_count        = corr_count_q;

endmodule

// File: tb/tb_secded_counter.sv
// Directed + randomized bench for secded_counter against an ideal-count reference model.
// Faults are planted by briefly forcing the storage registers before a clock edge.
module tb_secded_counter;

`ifdef SECDED_COUNTER_DED_EN
  localparam int P_TB = 6;
`else
  localparam int P_TB = 5;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, up_down, load;
  logic [15:0] load_value;
  logic [15:0] counter, counter2;
  logic        wrap, err_corrected, err_uncorrectable;
  logic        wrap2, err_corrected2, err_uncorrectable2;
  logic [7:0]  corr_count;
  logic [1:0]  corr_count2;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_cnt, m_raw;
  logic        m_unc, m_wrap, m_ec;
  int          m_cc, m_cc2;
  int          pulses;

  always #5 clk = ~clk;

  secded_counter #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .counter(counter), .wrap(wrap),
    .err_corrected(err_corrected), .err_uncorrectable(err_uncorrectable),
    .corr_count(corr_count)
  );

  secded_counter #(.WIDTH(16), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .counter(counter2), .wrap(wrap2),
    .err_corrected(err_corrected2), .err_uncorrectable(err_uncorrectable2),
    .corr_count(corr_count2)
  );

  // Reference encoder: lay the data out on codeword positions 1..21, then parity by position bits.
  function automatic logic [5:0] ref_parity(input logic [15:0] d);
    logic [21:0] cw;
    logic [5:0]  p;
    int          k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos <= 21; pos++) begin
      if (pos != 1 && pos != 2 && pos != 4 && pos != 8 && pos != 16) begin
        cw[pos] = d[k];
        k++;
      end
    end
    p = '0;
    for (int j = 0; j < 5; j++)
      for (int pos = 1; pos <= 21; pos++)
        if (((pos >> j) & 1) == 1) p[j] = p[j] ^ cw[pos];
    p[5] = (^d) ^ (^p[4:0]);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 none, 1 single data bit b0, 2 single parity bit b0, 3 data bits b0 and b1
  task automatic inject(input int kind, input int b0, input int b1);
    logic [15:0]     d1, d2;
    logic [P_TB-1:0] p1, p2;
    d1 = dut.count_reg_q;
    d2 = dut_sat.count_reg_q;
    p1 = dut.parity_stored_q;
    p2 = dut_sat.parity_stored_q;
    if (kind == 2) begin
      p1[b0] = ~p1[b0];
      p2[b0] = ~p2[b0];
      force dut.parity_stored_q = p1;
      force dut_sat.parity_stored_q = p2;
      #1;
      release dut.parity_stored_q;
      release dut_sat.parity_stored_q;
    end else begin
      d1[b0] = ~d1[b0];
      d2[b0] = ~d2[b0];
      if (kind == 3) begin
        d1[b1] = ~d1[b1];
        d2[b1] = ~d2[b1];
      end
      force dut.count_reg_q = d1;
      force dut_sat.count_reg_q = d2;
      #1;
      release dut.count_reg_q;
      release dut_sat.count_reg_q;
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic step(input logic rst, input logic ld, input logic [15:0] lv, input logic en,
                      input logic ud, input int kind, input int b0, input int b1);
    logic [15:0] pre_exp, mask;
    logic [5:0]  pmask;
    reset = rst; load = ld; load_value = lv; enable = en; up_down = ud;
    mask = (16'h1 << b0);
    if (kind == 3) mask = mask | (16'h1 << b1);
    if (kind != 0) begin
      #1;
      inject(kind, b0, b1);
      #1;
      pre_exp = (kind == 3) ? (m_cnt ^ mask) : (m_unc ? m_raw : m_cnt);
      chk("counter_pre_edge", 64'(counter), 64'(pre_exp));
    end
    if (rst) begin
      m_cnt = '0; m_unc = 0; m_wrap = 0; m_ec = 0; m_cc = 0; m_cc2 = 0;
    end else if (ld) begin
      m_cnt = lv; m_unc = 0; m_wrap = 0; m_ec = 0;
    end else begin
      m_ec   = (kind == 1 || kind == 2);
      m_wrap = 0;
      if (m_ec) begin
        if (m_cc < 255) m_cc++;
        if (m_cc2 < 3) m_cc2++;
      end
      if (kind == 3) begin
        m_unc = 1;
        m_raw = m_cnt ^ mask;
      end
      if (!m_unc && en) begin
        m_wrap = ud ? (m_cnt == 16'hFFFF) : (m_cnt == 16'h0000);
        m_cnt  = ud ? m_cnt + 16'd1 : m_cnt - 16'd1;
      end
    end
    @(posedge clk);
    #1;
    chk("counter", 64'(counter), 64'(m_unc ? m_raw : m_cnt));
    chk("wrap", 64'(wrap), 64'(m_wrap));
    chk("err_corrected", 64'(err_corrected), 64'(m_ec));
    chk("err_uncorrectable", 64'(err_uncorrectable), 64'(m_unc));
    chk("corr_count", 64'(corr_count), 64'(m_cc));
    chk("corr_count_sat", 64'(corr_count2), 64'(m_cc2));
    if (err_corrected2) pulses++;
    pmask = (P_TB == 6) ? 6'h3F : 6'h1F;
    if (!m_unc) chk("parity_scrubbed", 64'(dut.parity_stored_q), 64'(ref_parity(m_cnt) & pmask));
  endtask

  initial begin
    int kind, b0, b1;
    logic ld, en, ud;
    reset = 1; load = 0; enable = 0; up_down = 1; load_value = '0;
    m_cnt = '0; m_raw = '0; m_unc = 0; m_wrap = 0; m_ec = 0; m_cc = 0; m_cc2 = 0; pulses = 0;
    @(posedge clk);
    #1;
    step(1, 0, 16'h0, 0, 1, 0, 0, 0);

    // Count up ten cycles from reset
    for (int i = 0; i < 10; i++) step(0, 0, 16'h0, 1, 1, 0, 0, 0);
    chk("count_to_10", 64'(counter), 64'h000A);

    // Single data upset at 0x0005 while counting: corrected value is counted
    step(0, 1, 16'h0005, 0, 1, 0, 0, 0);
    step(0, 0, 16'h0, 1, 1, 1, 3, 0);
    chk("corrected_then_incremented", 64'(counter), 64'h0006);
    step(0, 0, 16'h0, 0, 1, 0, 0, 0);

    // Parity-bit upset, idle
    step(0, 0, 16'h0, 0, 1, 2, 2, 0);
    step(0, 0, 16'h0, 0, 1, 0, 0, 0);

    // Error together with load: load wins, no pulse
    step(0, 1, 16'hBEEF, 1, 1, 1, 7, 0);
    // Error together with reset: reset wins
    step(1, 0, 16'h0, 1, 1, 1, 9, 0);

    // Out-of-range double error: sticky, count frozen, load recovers
    step(0, 1, 16'h0100, 0, 1, 0, 0, 0);
    step(0, 0, 16'h0, 1, 1, 3, 15, 5);
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0, 1, 1, 0, 0, 0);
    step(0, 1, 16'h1234, 0, 1, 0, 0, 0);
    step(0, 0, 16'h0, 1, 1, 0, 0, 0);
    chk("resume_after_load", 64'(counter), 64'h1235);

`ifdef SECDED_COUNTER_DED_EN
    // In-range double error caught only by overall parity
    step(0, 0, 16'h0, 1, 1, 3, 0, 5);
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0, 1, 1, 0, 0, 0);
    step(0, 1, 16'h1234, 0, 1, 0, 0, 0);
    step(0, 0, 16'h0, 1, 1, 0, 0, 0);
    // Overall parity bit itself flipped
    step(0, 0, 16'h0, 0, 1, 2, 5, 0);
`endif

    // Reset while the sticky flag is set
    step(0, 0, 16'h0, 1, 1, 3, 15, 5);
    step(1, 0, 16'h0, 1, 1, 0, 0, 0);

    // Wrap both directions; load itself never wraps
    step(0, 1, 16'hFFFF, 0, 1, 0, 0, 0);
    step(0, 0, 16'h0, 1, 1, 0, 0, 0);
    chk("wrap_up_value", 64'(counter), 64'h0000);
    step(0, 0, 16'h0, 0, 1, 0, 0, 0);
    step(0, 1, 16'h0000, 0, 0, 0, 0, 0);
    step(0, 0, 16'h0, 1, 0, 0, 0, 0);
    chk("wrap_down_value", 64'(counter), 64'hFFFF);
    step(0, 0, 16'h0, 0, 0, 0, 0, 0);

    // Saturation of the 2-bit correction counter over five separate upsets
    step(1, 0, 16'h0, 0, 1, 0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 16'h0, 1, 1, 1, i * 3, 0);
      step(0, 0, 16'h0, 1, 1, 0, 0, 0);
    end
    chk("sat_pulses", 64'(pulses), 64'd5);
    chk("sat_value", 64'(corr_count2), 64'd3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom_range(0, 15) == 0) || (m_unc && $urandom_range(0, 3) == 0);
      en = $urandom_range(0, 3) != 0;
      ud = $urandom_range(0, 1) == 1;
      kind = 0; b0 = 0; b1 = 0;
      if (!m_unc) begin
        case ($urandom_range(0, 31))
          0, 1, 2: begin kind = 1; b0 = $urandom_range(0, 15); end
          3, 4:    begin kind = 2; b0 = $urandom_range(0, P_TB - 1); end
          5:       begin kind = 3; b0 = 15; b1 = 5; end
          default: kind = 0;
        endcase
      end
      step(0, ld, 16'($urandom), en, ud, kind, b0, b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
